// File: rtl/rb2_arb_pkg.sv
// Shared types and constants for the RB2 two-port arbiter.
package rb2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic RB2_RW_WRITE = 1'b0;
  localparam logic RB2_RW_READ  = 1'b1;

  localparam int unsigned RB2_DATA_W = 18;
  localparam int unsigned RB2_ADDR_W = 3;

endpackage

// File: rtl/rb2_arb_rr.sv
// Round-robin next-owner pick for the RB2 arbiter; purely combinational.
module rb2_arb_rr
  import rb2_arb_pkg::*;
(
  input  arb_state_e state_i,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_i,
  input  logic       limit_i,
  output arb_state_e state_o,
  output logic       last_o,
  output logic       release_o
);

  always_comb begin
    state_o   = state_i;
    last_o    = last_i;
    release_o = 1'b0;
    case (state_i)
      IDLE: begin
        if (req0_i && req1_i) state_o = last_i ? OWN0 : OWN1;
        else if (req0_i)      state_o = OWN0;
        else if (req1_i)      state_o = OWN1;
      end
      OWN0: begin
        release_o = !req0_i || (limit_i && req1_i);
        if (release_o) begin
          last_o  = 1'b0;
          state_o = req1_i ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        release_o = !req1_i || (limit_i && req0_i);
        if (release_o) begin
          last_o  = 1'b1;
          state_o = req0_i ? OWN0 : IDLE;
        end
      end
      default: state_o = IDLE;
    endcase
  end

endmodule

// File: rtl/rb2_port_arbiter.sv
// Shares the single RB2 bank port between two req/gnt requesters.
// Define RB2_ARB_BURST_LIMIT_EN to cap each grant tenure at MAX_BURST commands.
module rb2_port_arbiter
  import rb2_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = RB2_DATA_W,
  parameter int unsigned ADDR_W    = RB2_ADDR_W,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  output logic              gnt0,
  output logic              gnt1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] a0,
  input  logic [ADDR_W-1:0] a1,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] q0,
  output logic [DATA_W-1:0] q1,
  output logic              qv0,
  output logic              qv1,
  output logic              RB2_RW,
  output logic [ADDR_W-1:0] RB2_A,
  output logic [DATA_W-1:0] RB2_D,
  input  logic [DATA_W-1:0] RB2_Q
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       rel, limit_hit;
  logic       acc0, acc1;

  logic              cmd_rw_q, cmd_rw_d;
  logic [ADDR_W-1:0] cmd_a_q, cmd_a_d;
  logic [DATA_W-1:0] cmd_d_q, cmd_d_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_src_q, rd_src_d;
  logic [DATA_W-1:0] q0_q, q0_d, q1_q, q1_d;
  logic              qv0_q, qv0_d, qv1_q, qv1_d;

  rb2_arb_rr u_rr (
    .state_i   (state_q),
    .req0_i    (req0),
    .req1_i    (req1),
    .last_i    (last_q),
    .limit_i   (limit_hit),
    .state_o   (state_d),
    .last_o    (last_d),
    .release_o (rel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    gnt0 = (state_q == OWN0);
    gnt1 = (state_q == OWN1);
  end

  // A releasing edge never accepts, which yields the one-cycle handover gap.
  assign acc0 = gnt0 && req0 && !rel;
  assign acc1 = gnt1 && req1 && !rel;

`ifdef RB2_ARB_BURST_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign limit_hit = (cnt_q == CNT_W'(MAX_BURST));

  // At the cap with no competitor the tenure restarts, counting this accept.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE || state_d != state_q) cnt_d = '0;
    else if (limit_hit)                         cnt_d = (acc0 || acc1) ? CNT_W'(1) : '0;
    else if (acc0 || acc1)                      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    cmd_rw_d  = RB2_RW_READ;
    cmd_a_d   = cmd_a_q;
    cmd_d_d   = cmd_d_q;
    rd_pend_d = 1'b0;
    rd_src_d  = rd_src_q;
    if (acc0) begin
      cmd_rw_d  = rw0;
      cmd_a_d   = a0;
      cmd_d_d   = d0;
      rd_pend_d = (rw0 == RB2_RW_READ);
      rd_src_d  = 1'b0;
    end else if (acc1) begin
      cmd_rw_d  = rw1;
      cmd_a_d   = a1;
      cmd_d_d   = d1;
      rd_pend_d = (rw1 == RB2_RW_READ);
      rd_src_d  = 1'b1;
    end
  end

  always_comb begin
    q0_d  = q0_q;
    q1_d  = q1_q;
    qv0_d = 1'b0;
    qv1_d = 1'b0;
    if (rd_pend_q && !rd_src_q) begin
      q0_d  = RB2_Q;
      qv0_d = 1'b1;
    end
    if (rd_pend_q && rd_src_q) begin
      q1_d  = RB2_Q;
      qv1_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_rw_q  <= RB2_RW_READ;
      cmd_a_q   <= '0;
      cmd_d_q   <= '0;
      rd_pend_q <= 1'b0;
      rd_src_q  <= 1'b0;
      q0_q      <= '0;
      q1_q      <= '0;
      qv0_q     <= 1'b0;
      qv1_q     <= 1'b0;
    end else begin
      cmd_rw_q  <= cmd_rw_d;
      cmd_a_q   <= cmd_a_d;
      cmd_d_q   <= cmd_d_d;
      rd_pend_q <= rd_pend_d;
      rd_src_q  <= rd_src_d;
      q0_q      <= q0_d;
      q1_q      <= q1_d;
      qv0_q     <= qv0_d;
      qv1_q     <= qv1_d;
    end
  end

  assign RB2_RW = cmd_rw_q;
  assign RB2_A  = cmd_a_q;
  assign RB2_D  = cmd_d_q;
  assign q0     = q0_q;
  assign q1     = q1_q;
  assign qv0    = qv0_q;
  assign qv1    = qv1_q;

endmodule

// File: tb/tb_rb2_port_arbiter.sv
// Self-checking bench for rb2_port_arbiter: vector table, read scoreboard, corner sequences.
module tb_rb2_port_arbiter;

  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0, req1, rw0, rw1;
  logic [2:0]  a0, a1;
  logic [17:0] d0, d1;
  logic        gnt0, gnt1, qv0, qv1;
  logic [17:0] q0, q1;
  logic        rb2_rw;
  logic [2:0]  rb2_a;
  logic [17:0] rb2_d, rb2_q;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rb2_port_arbiter #(.DATA_W(18), .ADDR_W(3), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .rw0(rw0), .rw1(rw1), .a0(a0), .a1(a1), .d0(d0), .d1(d1),
    .q0(q0), .q1(q1), .qv0(qv0), .qv1(qv1),
    .RB2_RW(rb2_rw), .RB2_A(rb2_a), .RB2_D(rb2_d), .RB2_Q(rb2_q)
  );

  // Bank model: combinational read, write captured on the edge after RB2_RW=0.
  logic [17:0] bank [8] = '{18'h01111, 18'h02222, 18'h03333, 18'h04444,
                            18'h05555, 18'h06666, 18'h07777, 18'h08888};
  assign rb2_q = bank[rb2_a];
  always @(posedge clk) if (rb2_rw == 1'b0) bank[rb2_a] <= rb2_d;

  // Expected bank contents, maintained by the bench from its own writes.
  logic [17:0] em [8] = '{18'h01111, 18'h02222, 18'h03333, 18'h04444,
                          18'h05555, 18'h06666, 18'h07777, 18'h08888};

  typedef struct {
    logic port;
    logic [17:0] data;
  } rd_t;
  rd_t sb[$];

  typedef struct {
    logic r0, rw0; logic [2:0] a0; logic [17:0] d0;
    logic r1, rw1; logic [2:0] a1; logic [17:0] d1;
    logic g0, g1; logic [21:0] bus; logic qv0, qv1;
    logic push; logic pport; logic [17:0] pdata;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; rw0 = 1'b1; a0 = 3'd0; d0 = 18'd0;
    req1 = 1'b0; rw1 = 1'b1; a1 = 3'd0; d1 = 18'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk(nm, {gnt0, gnt1, qv0, qv1, rb2_rw, rb2_a, rb2_d}, {4'b0000, 1'b1, 3'd0, 18'd0});
    chk({nm, "_q"}, {q0, q1}, 36'd0);
  endtask

  // Monitor: grant exclusivity every cycle, and every qv pulse against the scoreboard.
  always begin
    rd_t e;
    @(posedge clk);
    #1;
    chk("one_gnt", {63'd0, gnt0 & gnt1}, 64'd0);
    if (qv0 || qv1) begin
      if (sb.size() == 0) begin
        chk("qv_unexpected", {62'd0, qv1, qv0}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rd_port", {62'd0, qv1, qv0}, e.port ? 64'd2 : 64'd1);
        chk("rd_data", e.port ? q1 : q0, e.data);
      end
    end
  end

  initial begin
    int cmd_act, cmd_exp, own;

    tbl[0] = '{1'b1, 1'b0, 3'd3, 18'h2A5A5, 1'b0, 1'b1, 3'd0, 18'd0,
               1'b1, 1'b0, {1'b1, 3'd0, 18'd0},      1'b0, 1'b0, 1'b0, 1'b0, 18'd0};
    tbl[1] = '{1'b1, 1'b0, 3'd3, 18'h2A5A5, 1'b0, 1'b1, 3'd0, 18'd0,
               1'b1, 1'b0, {1'b0, 3'd3, 18'h2A5A5}, 1'b0, 1'b0, 1'b0, 1'b0, 18'd0};
    tbl[2] = '{1'b0, 1'b0, 3'd3, 18'h2A5A5, 1'b1, 1'b1, 3'd3, 18'd0,
               1'b0, 1'b1, {1'b1, 3'd3, 18'h2A5A5}, 1'b0, 1'b0, 1'b0, 1'b0, 18'd0};
    tbl[3] = '{1'b0, 1'b0, 3'd3, 18'h2A5A5, 1'b1, 1'b1, 3'd3, 18'd0,
               1'b0, 1'b1, {1'b1, 3'd3, 18'd0},      1'b0, 1'b0, 1'b1, 1'b1, 18'h2A5A5};
    tbl[4] = '{1'b0, 1'b0, 3'd3, 18'h2A5A5, 1'b0, 1'b1, 3'd3, 18'd0,
               1'b0, 1'b0, {1'b1, 3'd3, 18'd0},      1'b0, 1'b1, 1'b0, 1'b0, 18'd0};
    tbl[5] = '{1'b0, 1'b0, 3'd3, 18'h2A5A5, 1'b0, 1'b1, 3'd3, 18'd0,
               1'b0, 1'b0, {1'b1, 3'd3, 18'd0},      1'b0, 1'b0, 1'b0, 1'b0, 18'd0};

    // Reset values while rst is held.
    idle_inputs();
    rst = 1'b1;
    #2;
    chk_reset_outs("reset");
    step();
    rst = 1'b0;

    // Port 0 write to addr 3, handover, port 1 reads it back.
    em[3] = 18'h2A5A5;
    for (int i = 0; i < 6; i++) begin
      req0 = tbl[i].r0; rw0 = tbl[i].rw0; a0 = tbl[i].a0; d0 = tbl[i].d0;
      req1 = tbl[i].r1; rw1 = tbl[i].rw1; a1 = tbl[i].a1; d1 = tbl[i].d1;
      if (tbl[i].push) sb.push_back('{tbl[i].pport, tbl[i].pdata});
      step();
      chk($sformatf("vec%0d_gnt", i), {62'd0, gnt0, gnt1}, {62'd0, tbl[i].g0, tbl[i].g1});
      chk($sformatf("vec%0d_bus", i), {42'd0, rb2_rw, rb2_a, rb2_d}, {42'd0, tbl[i].bus});
      chk($sformatf("vec%0d_qv", i), {62'd0, qv0, qv1}, {62'd0, tbl[i].qv0, tbl[i].qv1});
    end

    // Simultaneous requests from reset: port 0 wins, handover on req0 drop.
    do_reset();
    req0 = 1'b1; rw0 = 1'b0; a0 = 3'd5; d0 = em[5];
    req1 = 1'b1; rw1 = 1'b0; a1 = 3'd6; d1 = em[6];
    for (int k = 0; k < 4; k++) begin
      step();
      chk("tie_gnt", {62'd0, gnt0, gnt1}, 64'd2);
    end
    req0 = 1'b0;
    step();
    chk("handover_gnt", {62'd0, gnt0, gnt1}, 64'd1);
    step();
    chk("hold_gnt1", {62'd0, gnt0, gnt1}, 64'd1);
    req1 = 1'b0;
    step();
    chk("idle_gnt", {62'd0, gnt0, gnt1}, 64'd0);

    // Both ports requesting continuously: burst alternation or lock.
    do_reset();
    req0 = 1'b1; rw0 = 1'b0; a0 = 3'd5; d0 = em[5];
    req1 = 1'b1; rw1 = 1'b0; a1 = 3'd6; d1 = em[6];
    for (int k = 0; k < 20; k++) begin
      step();
`ifdef RB2_ARB_BURST_LIMIT_EN
      own = (k / (MB + 1)) % 2;
      if (k == 0 || ((k - 1) % (MB + 1)) == MB) cmd_exp = 0;
      else cmd_exp = ((k - 1) / (MB + 1)) % 2 + 1;
`else
      own = 0;
      cmd_exp = (k == 0) ? 0 : 1;
`endif
      if (rb2_rw) cmd_act = 0;
      else if (rb2_a == 3'd5) cmd_act = 1;
      else if (rb2_a == 3'd6) cmd_act = 2;
      else cmd_act = 3;
      chk($sformatf("burst_cmd%0d", k), 64'(cmd_act), 64'(cmd_exp));
      chk($sformatf("burst_gnt%0d", k), {62'd0, gnt0, gnt1}, (own == 0) ? 64'd2 : 64'd1);
    end
    idle_inputs();
    step();
    step();

    // Eight back-to-back reads on port 0.
    do_reset();
    req0 = 1'b1; rw0 = 1'b1; a0 = 3'd0;
    step();
    chk("b2b_qv_e0", {63'd0, qv0}, 64'd0);
    for (int k = 1; k <= 8; k++) begin
      a0 = 3'(k - 1);
      sb.push_back('{1'b0, em[k - 1]});
      step();
      chk($sformatf("b2b_qv_e%0d", k), {63'd0, qv0}, (k >= 2) ? 64'd1 : 64'd0);
    end
    req0 = 1'b0;
    step();
    chk("b2b_qv_e9", {63'd0, qv0}, 64'd1);
    step();
    chk("b2b_qv_e10", {63'd0, qv0}, 64'd0);

    // Reset with a port 1 read in flight: dropped, then clean regrant.
    do_reset();
    req1 = 1'b1; rw1 = 1'b1; a1 = 3'd2;
    step();
    chk("mid_gnt1", {62'd0, gnt0, gnt1}, 64'd1);
    step();
    rst = 1'b1;
    #1;
    chk_reset_outs("mid_rst");
    step();
    chk("mid_rst_noqv", {62'd0, qv0, qv1}, 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_gnt1", {62'd0, gnt0, gnt1}, 64'd1);
    req1 = 1'b0;
    step();
    step();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
